seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand width; result_o is 2*WIDTH wide; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  request; the initiator holds it high until ready_o is seen.
REQ-008 annul_i  input  1  abort the operation in progress.
REQ-009 result_o  output  64  {remainder[31:0], quotient[31:0]}, in hi/lo order.
REQ-010 ready_o  output  1  result valid; one-cycle pulse.

Function
REQ-011 The FSM SHALL have the states IDLE, DIVZERO, BUSY and DONE.
REQ-012 In IDLE with start_i=1 and annul_i=0, the block SHALL capture the operands and signed_div_i, then go to DIVZERO if opdata2_i==0, else to BUSY.
REQ-013 In IDLE, start_i=0 or annul_i=1 SHALL leave the block in IDLE, with no state change.
REQ-014 Operand changes after capture SHALL be ignored until the next accepted start.
REQ-015 Signed mode SHALL divide absolute values (two's-complement negate when bit 31=1); the unsigned path SHALL use the raw operands.
REQ-016 BUSY SHALL run exactly 32 restoring radix-2 iterations, one per cycle:
- shift {rem, dividend} left by 1;
- trial-subtract the divisor;
- if no borrow, keep the difference and set quotient bit = 1;
- iteration counter 0..31.
REQ-017 After iteration 31 the state SHALL be DONE.
REQ-018 Latency: start sampled at edge E0; ready_o=1 in the cycle following edge E32 (33 edges total).
REQ-019 DIVZERO SHALL go to DONE on the next edge with result 64'h0, giving ready_o in the cycle after E1.
REQ-020 On entering DONE, the signed correction SHALL be applied:
- quotient negated if dividend sign != divisor sign;
- remainder negated if the dividend was negative.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no flag).
REQ-022 ready_o SHALL be 1 only in DONE.
REQ-023 DONE SHALL go to IDLE unconditionally after one cycle, even if start_i is still high.
REQ-024 Because of REQ-023, a new operation SHALL be accepted no earlier than one cycle after DONE.
REQ-025 result_o SHALL hold its last value from DONE until the next DONE; it is registered, not combinational.
REQ-026 annul_i=1 in BUSY or DIVZERO SHALL return the FSM to IDLE on the next edge, with no ready_o and result_o unchanged.
REQ-027 annul_i in DONE SHALL be ignored; the result is already delivered.
REQ-028 If start_i and annul_i are both high in IDLE, annul SHALL win (nothing is accepted).

Reset
REQ-029 rst=0 SHALL immediately, asynchronously and regardless of clk, force:
- state IDLE;
- counter 0;
- result_o 64'h0;
- ready_o 0;
- all internal operand registers 0.
REQ-030 Reset during BUSY SHALL discard the operation; no ready_o SHALL follow deassertion unless a new start is accepted.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept start_i.

Structure
REQ-032 Shared package div_pkg SHALL hold:
- the state enum (IDLE, DIVZERO, BUSY, DONE);
- DIV_WIDTH=32;
- DIV_ITER=32;
- ZERO_RESULT=64'h0.
REQ-033 Single module, no sub-module; the absolute-value negation SHALL be a local function, not a separate block.
REQ-034 The datapath SHALL use one 33-bit subtractor, shared across iterations; one combinational divider is not permitted.

Verification
REQ-035 Unsigned 100/7 (signed_div_i=0), start held high -> ready_o after 33 edges, result_o={32'd2, 32'd14}, ready_o high exactly one cycle.
REQ-036 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-037 Divisor 0, dividend 0x12345678 -> ready_o in the cycle after the 2nd edge, result_o=64'h0.
REQ-038 Signed 0x80000000/0xFFFFFFFF -> result_o={0x00000000, 0x80000000}; unsigned 0xFFFFFFFF/0x00000001 -> {0, 0xFFFFFFFF}.
REQ-039 Start 100/7, annul_i pulsed at iteration 10 -> IDLE next cycle, no ready_o for 40 cycles, result_o keeps its prior value.
REQ-040 rst=0 mid-BUSY between clock edges -> state IDLE and result_o=0 at once; a new start 9/3 then yields {0, 3}, with no ready_o left over from the aborted operation.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider.
package div_pkg;

  localparam int          DIV_WIDTH   = 32;
  localparam int          DIV_ITER    = 32;
  localparam logic [63:0] ZERO_RESULT = 64'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Sequential signed/unsigned 32-bit divider: one restoring iteration per cycle
// through a single shared 33-bit subtractor; result is {remainder, quotient}.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(DIV_ITER);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       partial_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH-1:0]     iter_rem_s;
  logic [WIDTH-1:0]     iter_quo_s;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg_val(x) : x;
  endfunction

  // The quotient register doubles as the dividend shifter; bit WIDTH of the
  // difference is the borrow because the partial remainder is below 2*divisor.
  always_comb begin
    partial_s  = {rem_q, quo_q[WIDTH-1]};
    sub_s      = partial_s - {1'b0, dvs_q};
    iter_rem_s = sub_s[WIDTH] ? partial_s[WIDTH-1:0] : sub_s[WIDTH-1:0];
    iter_quo_s = {quo_q[WIDTH-2:0], ~sub_s[WIDTH]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          rem_d  = '0;
          cnt_d  = '0;
          quo_d  = signed_div_i ? abs_val(opdata1_i) : opdata1_i;
          dvs_d  = signed_div_i ? abs_val(opdata2_i) : opdata2_i;
          negq_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_div_i & opdata1_i[WIDTH-1];
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = ZERO_RESULT;
          ready_d  = 1'b1;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = iter_rem_s;
          quo_d = iter_quo_s;
          if (cnt_q == CW'(DIV_ITER - 1)) begin
            // Sign correction is folded into the final iteration's edge.
            state_d  = DONE;
            cnt_d    = '0;
            ready_d  = 1'b1;
            result_d = {negr_q ? neg_val(iter_rem_s) : iter_rem_s,
                        negq_q ? neg_val(iter_quo_s) : iter_quo_s};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; rst clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= ZERO_RESULT;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
